// File: rtl/pitch_pkg.sv
// Shared types and sizing helpers for the pitch-detection correlator path.
// The most-negative macro seeds the argmax so the first candidate always wins.
`ifndef PITCH_MOST_NEG
`define PITCH_MOST_NEG(W) {1'b1, {((W)-1){1'b0}}}
`endif

package pitch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // FLUSH holds until stage 3 has compared the final sum.
  localparam logic [1:0] FLUSH_LAST = 2'd2;

  function automatic int acc_width(input int data_w, input int frame_len);
    return 2 * data_w + $clog2(frame_len) + 1;
  endfunction

  function automatic int cnt_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/xcorr_mac.sv
// Registered multiply (stage 1) and accumulate (stage 2) for one candidate.
// The sum is flagged valid the cycle after the candidate's final product lands.
module xcorr_mac
  import pitch_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 11,
  localparam int ACC_W    = acc_width(DATA_W, FRAME_LEN)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic signed [DATA_W-1:0] i_cand_data,
  input  logic signed [DATA_W-1:0] i_ref_data,
  input  logic [IDX_W-1:0]         i_index,
  output logic                     o_sum_valid,
  output logic signed [ACC_W-1:0]  o_sum,
  output logic [IDX_W-1:0]         o_index
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] candExt, refExt, prod_d;
  logic signed [PROD_W-1:0] prod_q;
  logic                     s1Valid_q, s1First_q, s1Last_q;
  logic [IDX_W-1:0]         s1Index_q;

  logic signed [ACC_W-1:0]  prodExt, acc_d, acc_q;
  logic                     sumValid_q;
  logic [IDX_W-1:0]         index_q;

  assign candExt = {{DATA_W{i_cand_data[DATA_W-1]}}, i_cand_data};
  assign refExt  = {{DATA_W{i_ref_data[DATA_W-1]}}, i_ref_data};
  assign prod_d  = candExt * refExt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1Valid_q <= 1'b0;
      s1First_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Index_q <= '0;
      prod_q    <= '0;
    end else if (i_clear) begin
      s1Valid_q <= 1'b0;
      s1First_q <= 1'b0;
      s1Last_q  <= 1'b0;
      s1Index_q <= '0;
      prod_q    <= '0;
    end else begin
      s1Valid_q <= i_valid;
      if (i_valid) begin
        prod_q    <= prod_d;
        s1First_q <= i_first;
        s1Last_q  <= i_last;
        s1Index_q <= i_index;
      end
    end
  end

  // Gaps leave the partial sum untouched; a first flag restarts it.
  assign prodExt = {{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q};

  always_comb begin
    acc_d = acc_q;
    if (s1Valid_q) begin
      acc_d = s1First_q ? prodExt : (acc_q + prodExt);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q      <= '0;
      sumValid_q <= 1'b0;
      index_q    <= '0;
    end else if (i_clear) begin
      acc_q      <= '0;
      sumValid_q <= 1'b0;
      index_q    <= '0;
    end else begin
      acc_q      <= acc_d;
      sumValid_q <= s1Valid_q & s1Last_q;
      if (s1Valid_q && s1First_q) begin
        index_q <= s1Index_q;
      end
    end
  end

  assign o_sum_valid = sumValid_q;
  assign o_sum       = acc_q;
  assign o_index     = index_q;

endmodule

// File: rtl/xcorr_peak_search.sv
// Streams candidate frames against a reference frame and reports the index
// of the candidate with the largest dot product, with a done pulse per search.
module xcorr_peak_search
  import pitch_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 4,
  parameter int IDX_W     = 11,
  parameter int TIE_LAST  = 0,
  localparam int ACC_W    = acc_width(DATA_W, FRAME_LEN)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_cand_data,
  input  logic signed [DATA_W-1:0] i_ref_data,
  input  logic [IDX_W-1:0]         i_cand_index,
  input  logic                     i_last_cand,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [IDX_W-1:0]         o_index,
  output logic signed [ACC_W-1:0]  o_max_value
);

  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = `PITCH_MOST_NEG(ACC_W);

  state_e state_q, state_d;
  logic [1:0]       flush_q, flush_d;
  logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;

  logic                    sampleAccept, finalSample;
  logic                    sumValid;
  logic signed [ACC_W-1:0] sum;
  logic [IDX_W-1:0]        sumIndex;
  logic                    update;

  logic signed [ACC_W-1:0] bestMax_q, bestMax_d;
  logic [IDX_W-1:0]        bestIdx_q, bestIdx_d;

  // A start pulse wins over any sample presented in the same cycle.
  assign sampleAccept = (state_q == ACCUM) && i_valid && !i_start;
  assign finalSample  = (sampleCnt_q == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      flush_q     <= 2'd0;
      sampleCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      sampleCnt_q <= sampleCnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_start) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (sampleAccept && finalSample && i_last_cand) state_d = FLUSH;
        FLUSH:   if (flush_q == FLUSH_LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy = (state_q == ACCUM) || (state_q == FLUSH);
    o_done = (state_q == DONE);
  end

  always_comb begin
    flush_d     = (state_q == FLUSH) ? (flush_q + 2'd1) : 2'd0;
    sampleCnt_d = sampleCnt_q;
    if (i_start) begin
      sampleCnt_d = '0;
    end else if (sampleAccept) begin
      sampleCnt_d = finalSample ? '0 : (sampleCnt_q + 1'b1);
    end
  end

  xcorr_mac #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) u_mac (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_start),
    .i_valid     (sampleAccept),
    .i_first     (sampleCnt_q == '0),
    .i_last      (finalSample),
    .i_cand_data (i_cand_data),
    .i_ref_data  (i_ref_data),
    .i_index     (i_cand_index),
    .o_sum_valid (sumValid),
    .o_sum       (sum),
    .o_index     (sumIndex)
  );

  // Stage 3: argmax, with the tie policy picking earliest or latest index.
  always_comb begin
    update    = sumValid && ((sum > bestMax_q) || ((TIE_LAST != 0) && (sum == bestMax_q)));
    bestMax_d = bestMax_q;
    bestIdx_d = bestIdx_q;
    if (i_start) begin
      bestMax_d = ACC_MIN;
      bestIdx_d = '0;
    end else if (update) begin
      bestMax_d = sum;
      bestIdx_d = sumIndex;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bestMax_q <= '0;
      bestIdx_q <= '0;
    end else begin
      bestMax_q <= bestMax_d;
      bestIdx_q <= bestIdx_d;
    end
  end

  assign o_index     = bestIdx_q;
  assign o_max_value = bestMax_q;

endmodule
